// File: rtl/v_addsub_unit.sv
// ---------------------------------------------------------------------------
// v_addsub_unit
//
// Registered two's-complement adder/subtractor. This is the arithmetic
// primitive of the vector ALU. The ALU uses one instance per lane, four
// lanes in total.
//
// The unit computes S = A + B when ADD=1 and S = A - B when ADD=0, modulo
// 2^WIDTH. The ALU sign-extends the operands before they arrive, and it
// slices the narrow result out of S afterwards. Because of that, this block
// is width-agnostic and has no notion of element size.
//
// Parameters
//   WIDTH    operand/result width in bits (8..64)
//   LATENCY  enabled clock edges from input sample to S (1..4)
//
// Ports
//   CLK  in   1      rising-edge clock
//   RST  in   1      asynchronous active-high reset, clears every stage
//   A    in   WIDTH  minuend / first addend
//   B    in   WIDTH  subtrahend / second addend
//   ADD  in   1      1: A+B, 0: A-B
//   CE   in   1      clock enable, 0 freezes the whole pipeline
//   S    out  WIDTH  registered result (last pipeline stage)
// ---------------------------------------------------------------------------
module v_addsub_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ADD,
  input  logic             CE,
  output logic [WIDTH-1:0] S
);

  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] sum;

  // Subtraction reuses the adder as A + ~B + 1. The "+1" enters as a
  // zero-extended carry-in, so one adder serves both operations, and
  // A - 0 and 0 - 0 come out right with no special case.
  always_comb begin
    b_operand = ADD ? B : ~B;
    carry_in  = {{(WIDTH-1){1'b0}}, ~ADD};
    sum       = A + b_operand + carry_in;
  end

  logic [WIDTH-1:0] pipe [LATENCY];

  // Pipeline registers. Stage 0 captures the freshly computed sum, and each
  // later stage takes the value of the stage before it.
  // ADD is consumed here together with A/B. Later stages therefore carry
  // only finished results, and a change of ADD cannot disturb work already
  // in flight. When CE is low, every stage holds its value, which stalls the
  // pipeline instead of inserting bubbles.
  // Reset is asynchronous and clears all stages, so any in-flight results
  // are discarded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (CE) begin
      pipe[0] <= sum;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign S = pipe[LATENCY-1];

endmodule

// File: tb/tb_v_addsub_unit.sv
// ---------------------------------------------------------------------------
// tb_v_addsub_unit
//
// The bench drives two instances of v_addsub_unit (LATENCY 1 and LATENCY 3)
// from the same stimulus.
//
// For every enabled sample, the stimulus side pushes the arithmetic result
// A +/- B mod 2^32 into a per-instance queue. The monitor side checks S after
// every clock edge:
//   - An enabled edge makes the result queued LATENCY samples ago visible.
//   - A disabled edge leaves S unchanged.
//   - Reset empties the queues, and S must then read zero.
// ---------------------------------------------------------------------------
module tb_v_addsub_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic         ADD = 1'b1;
  logic         CE  = 1'b0;
  logic [W-1:0] s1;
  logic [W-1:0] s3;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] expQ1[$];
  logic [W-1:0] expQ3[$];
  logic [W-1:0] held1 = '0;
  logic [W-1:0] held3 = '0;
  logic         monEn;

  v_addsub_unit #(.WIDTH(W), .LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ADD(ADD), .CE(CE), .S(s1)
  );

  v_addsub_unit #(.WIDTH(W), .LATENCY(3)) dut3 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ADD(ADD), .CE(CE), .S(s3)
  );

  always #5 CLK = ~CLK;

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge. The reference result is
  // queued only when the coming rising edge will really sample it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic add, input logic ce, input logic rst);
    logic [W-1:0] ref_val;
    @(negedge CLK);
    RST = rst;
    A   = a;
    B   = b;
    ADD = add;
    CE  = ce;
    ref_val = add ? (a + b) : (a - b);
    if (ce && !rst) begin
      expQ1.push_back(ref_val);
      expQ3.push_back(ref_val);
    end
  endtask

  // Raise reset between clock edges, then hold it across one rising edge.
  task automatic pulseReset();
    @(negedge CLK);
    #2 RST = 1'b1;
    A  = $urandom;
    B  = $urandom;
    CE = 1'b1;
  endtask

  // Asynchronous reset: the model forgets everything, and S must clear at once.
  always @(posedge RST) begin
    expQ1.delete();
    expQ3.delete();
    held1 = '0;
    held3 = '0;
    #1;
    checkOutput("async_reset_lat1", s1, '0);
    checkOutput("async_reset_lat3", s3, '0);
  end

  // Monitor: after each rising edge, work out what each instance must show.
  always @(posedge CLK) begin
    monEn = CE && !RST;
    #1;
    if (RST) begin
      checkOutput("reset_hold_lat1", s1, '0);
      checkOutput("reset_hold_lat3", s3, '0);
    end else begin
      if (monEn) begin
        if (expQ1.size() >= 1) held1 = expQ1.pop_front();
        if (expQ3.size() >= 3) held3 = expQ3.pop_front();
      end
      checkOutput("s_lat1", s1, held1);
      checkOutput("s_lat3", s3, held3);
    end
  end

  initial begin
    // Hold reset while CE toggles and inputs are live, then release it.
    for (int i = 0; i < 4; i++) applyStimulus(32'd5, 32'd3, 1'b1, i[0], 1'b1);
    applyStimulus(32'd5, 32'd3, 1'b1, 1'b1, 1'b0);

    // Wrap-around on addition, then subtraction with negative results.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FF80, 32'hFFFF_FF81, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Clock-enable stall: the new operands must not leak through while CE=0.
    applyStimulus(32'd10, 32'd20, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'd1, 32'd1, 1'b1, 1'b1, 1'b0);

    // Back-to-back stream with ADD flipping on every cycle.
    for (int i = 0; i < 8; i++) applyStimulus(32'd100, W'(i), ~i[0], 1'b1, 1'b0);

    // Reset in the middle of a stream, then restart.
    for (int i = 0; i < 2; i++) applyStimulus(32'd7, W'(i), 1'b1, 1'b1, 1'b0);
    pulseReset();
    for (int i = 0; i < 5; i++) applyStimulus(32'd50, W'(i), i[0], 1'b1, 1'b0);

    // Random vectors with random enable, plus an occasional mid-stream reset.
    for (int i = 0; i < 10000; i++) begin
      if (i % 2500 == 1234) pulseReset();
      applyStimulus($urandom, $urandom, 1'($urandom), ($urandom_range(0, 4) != 0), 1'b0);
    end

    // Drain the pipeline, then idle with CE low so S must hold.
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus($urandom, $urandom, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
